mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl : multi-cycle main controller for the MIPS core.
//
// Sequences every instruction through S_IF -> S_ID -> S_EX -> S_MEM -> S_WB,
// driving the single-cycle datapath control encodings one phase at a time.
// Instruction and data memories may stall via their ready inputs; a wait
// counter aborts a stalled access after WAIT_MAX cycles (0 = never abort).
//
// Optional feature macro: MC_CTRL_PERF_EN
//   defined   -> cycle_cnt / instr_cnt performance counters are built
//   undefined -> both counter outputs are tied to zero
//
// Parameters
//   WAIT_MAX  max cycles spent waiting on a memory ready (0 disables timeout)
//   CNT_W     width of the performance counters
//
// Ports
//   Clk, Rst_n          clock (rising edge), async active-low reset
//   op, func, branop    IR[31:26], IR[5:0], IR[20:16]
//   imem_rdy, dmem_rdy  memory ready handshakes
//   imem_req, dmem_req  memory request strobes
//   IRWr, PCWr          latch IR / write PC+4
//   RegWr, ExtOp, ALUSrc, RegDst, Jump, MemtoReg, Branch, MemWr
//                       datapath controls, single-cycle encodings
//   illegal, bus_err    one-cycle pulses: unknown op/func, memory timeout
//   cycle_cnt, instr_cnt performance counters
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mc_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [4:0]       branop,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       Jump,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       Branch,
  output logic [2:0]       MemWr,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int            WW       = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit            TO_EN    = (WAIT_MAX > 0);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4,
    C_LINK   = 3'd5
  } cls_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q;
  logic            leave;      // current state is exited this cycle
  logic            count_en;   // stalled memory phase, bump wait counter

  // combinational decode of the IR fields (only consumed in S_ID)
  logic            dec_legal;
  cls_e            dec_cls;
  logic            dec_ext, dec_alusrc;
  logic [1:0]      dec_regdst, dec_memtoreg, dec_jump;
  logic [2:0]      dec_branch, dec_memwr;

  // decode latched at the end of S_ID; later phases only look at these
  cls_e            l_cls;
  logic            l_ext, l_alusrc;
  logic [1:0]      l_regdst, l_memtoreg, l_jump;
  logic [2:0]      l_branch, l_memwr;

  logic at_limit;
  assign at_limit = TO_EN && (wait_q == WAIT_LIM);

  // Instruction decode: class plus every field encoding the later phases need.
  always_comb begin
    dec_legal    = 1'b1;
    dec_cls      = C_ALU;
    dec_ext      = 1'b0;
    dec_alusrc   = 1'b0;
    dec_regdst   = 2'b00;
    dec_memtoreg = 2'b00;
    dec_jump     = 2'b00;
    dec_branch   = 3'b000;
    dec_memwr    = 3'b000;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011, 6'b000000, 6'b000010,
          6'b000011, 6'b000100, 6'b000110, 6'b000111: dec_regdst = 2'b01;
          6'b001000: begin
            dec_cls  = C_JUMP;
            dec_jump = 2'b10;
          end
          6'b001001: begin
            dec_cls      = C_LINK;
            dec_jump     = 2'b10;
            dec_regdst   = 2'b10;
            dec_memtoreg = 2'b11;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'b000001: begin
        dec_cls = C_BRANCH;
        dec_ext = 1'b1;
        case (branop)
          5'b00000: dec_branch = 3'b110;
          5'b00001: dec_branch = 3'b011;
          default:  dec_legal  = 1'b0;
        endcase
      end
      6'b000010: begin
        dec_cls  = C_JUMP;
        dec_jump = 2'b01;
      end
      6'b000011: begin
        dec_cls      = C_LINK;
        dec_jump     = 2'b01;
        dec_regdst   = 2'b10;
        dec_memtoreg = 2'b11;
      end
      6'b000100: begin dec_cls = C_BRANCH; dec_ext = 1'b1; dec_branch = 3'b001; end
      6'b000101: begin dec_cls = C_BRANCH; dec_ext = 1'b1; dec_branch = 3'b010; end
      6'b000110: begin dec_cls = C_BRANCH; dec_ext = 1'b1; dec_branch = 3'b101; end
      6'b000111: begin dec_cls = C_BRANCH; dec_ext = 1'b1; dec_branch = 3'b100; end
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_ext    = 1'b1;
        dec_alusrc = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: dec_alusrc = 1'b1;
      6'b001111: begin
        dec_alusrc   = 1'b1;
        dec_memtoreg = 2'b10;
      end
      6'b100011, 6'b100000, 6'b100100: begin
        dec_cls      = C_LOAD;
        dec_ext      = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 2'b01;
        dec_memwr    = (op == 6'b100000) ? 3'b010 :
                       (op == 6'b100100) ? 3'b011 : 3'b000;
      end
      6'b101011, 6'b101000: begin
        dec_cls    = C_STORE;
        dec_ext    = 1'b1;
        dec_alusrc = 1'b1;
        dec_memwr  = (op == 6'b101000) ? 3'b101 : 3'b001;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next state and phase outputs. Everything is held low while Rst_n is low
  // so no partial write can escape during an asynchronous abort.
  always_comb begin
    state_d  = state_q;
    leave    = 1'b0;
    count_en = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RegWr    = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    RegDst   = 2'b00;
    Jump     = 2'b00;
    MemtoReg = 2'b00;
    Branch   = 3'b000;
    MemWr    = 3'b000;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (Rst_n) begin
      case (state_q)
        S_IF: begin
          // ready wins over a timeout landing on the same cycle
          if (imem_rdy) begin
            imem_req = 1'b1;
            IRWr     = 1'b1;
            PCWr     = 1'b1;
            leave    = 1'b1;
            state_d  = S_ID;
          end else if (at_limit) begin
            bus_err  = 1'b1;
            leave    = 1'b1;
            state_d  = S_IF;
          end else begin
            imem_req = 1'b1;
            count_en = TO_EN;
          end
        end
        S_ID: begin
          leave = 1'b1;
          if (dec_legal) begin
            state_d = S_EX;
          end else begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        end
        S_EX: begin
          leave  = 1'b1;
          ExtOp  = l_ext;
          ALUSrc = l_alusrc;
          case (l_cls)
            C_BRANCH: begin
              Branch  = l_branch;
              state_d = S_IF;
            end
            C_JUMP: begin
              Jump    = l_jump;
              state_d = S_IF;
            end
            C_LINK: begin
              Jump     = l_jump;
              RegWr    = 1'b1;
              RegDst   = l_regdst;
              MemtoReg = l_memtoreg;
              state_d  = S_IF;
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            C_ALU:           state_d = S_WB;
            default:         state_d = S_IF;
          endcase
        end
        S_MEM: begin
          if (dmem_rdy) begin
            dmem_req = 1'b1;
            MemWr    = l_memwr;
            leave    = 1'b1;
            state_d  = (l_cls == C_LOAD) ? S_WB : S_IF;
          end else if (at_limit) begin
            bus_err  = 1'b1;
            leave    = 1'b1;
            state_d  = S_IF;
          end else begin
            dmem_req = 1'b1;
            MemWr    = l_memwr;
            count_en = TO_EN;
          end
        end
        S_WB: begin
          RegWr    = 1'b1;
          RegDst   = l_regdst;
          MemtoReg = l_memtoreg;
          leave    = 1'b1;
          state_d  = S_IF;
        end
        default: begin
          leave   = 1'b1;
          state_d = S_IF;
        end
      endcase
    end else begin
      state_d = S_IF;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Wait counter: cleared on every state exit, counts stalled memory cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        wait_q <= '0;
    else if (leave)    wait_q <= '0;
    else if (count_en) wait_q <= wait_q + WW'(1);
    else               wait_q <= wait_q;
  end

  // Decode latch, captured on the last (only) cycle of S_ID.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      l_cls      <= C_ALU;
      l_ext      <= 1'b0;
      l_alusrc   <= 1'b0;
      l_regdst   <= 2'b00;
      l_memtoreg <= 2'b00;
      l_jump     <= 2'b00;
      l_branch   <= 3'b000;
      l_memwr    <= 3'b000;
    end else if (state_q == S_ID) begin
      l_cls      <= dec_cls;
      l_ext      <= dec_ext;
      l_alusrc   <= dec_alusrc;
      l_regdst   <= dec_regdst;
      l_memtoreg <= dec_memtoreg;
      l_jump     <= dec_jump;
      l_branch   <= dec_branch;
      l_memwr    <= dec_memwr;
    end else begin
      l_cls      <= l_cls;
      l_ext      <= l_ext;
      l_alusrc   <= l_alusrc;
      l_regdst   <= l_regdst;
      l_memtoreg <= l_memtoreg;
      l_jump     <= l_jump;
      l_branch   <= l_branch;
      l_memwr    <= l_memwr;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instr_q;
  logic             instr_done;

  // An instruction retires on a normal return to S_IF from a late phase;
  // illegal aborts leave from S_ID and timeouts raise bus_err, so neither counts.
  assign instr_done = Rst_n && !bus_err && (state_d == S_IF) &&
                      ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB));

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      instr_q <= instr_done ? (instr_q + CNT_W'(1)) : instr_q;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl : self-checking bench for mc_ctrl.
// Each instruction is expanded by a phase-level reference model into the
// expected per-cycle control vector; directed cases come first, then a run of
// random instructions with random wait states and random junk on inputs that
// the controller must ignore.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mc_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 8;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [5:0]       op, func;
  logic [4:0]       branop;
  logic             imem_rdy, dmem_rdy;
  logic             imem_req, dmem_req, IRWr, PCWr, RegWr, ExtOp, ALUSrc;
  logic [1:0]       RegDst, Jump, MemtoReg;
  logic [2:0]       Branch, MemWr;
  logic             illegal, bus_err;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .op(op), .func(func), .branop(branop),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWr(IRWr), .PCWr(PCWr),
    .RegWr(RegWr), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .Jump(Jump), .MemtoReg(MemtoReg), .Branch(Branch), .MemWr(MemWr),
    .illegal(illegal), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       imem_req, dmem_req, irwr, pcwr, regwr, extop, alusrc;
    logic [1:0] regdst, jump, memtoreg;
    logic [2:0] branch, memwr;
    logic       illegal, bus_err;
  } ctl_t;

  // instruction kinds used by the model
  localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2,
                         K_BR  = 3'd3, K_JMP  = 3'd4, K_LINK  = 3'd5;

  typedef struct packed {
    logic       legal;
    logic [2:0] kind;
    logic       ext, alusrc;
    logic [1:0] regdst, memtoreg, jump;
    logic [2:0] branch, memwr;
  } dec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc_m = 32'd0;
  logic [31:0] instr_m = 32'd0;

  // Reference decode from the instruction-set table, by opcode/func number.
  function automatic dec_t ref_decode(logic [5:0] o, logic [5:0] f, logic [4:0] b);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    if (o == 6'd0) begin
      if (f == 6'd8) begin
        d.kind = K_JMP; d.jump = 2'd2;
      end else if (f == 6'd9) begin
        d.kind = K_LINK; d.jump = 2'd2; d.regdst = 2'd2; d.memtoreg = 2'd3;
      end else if ((f >= 6'd32 && f <= 6'd39) || f == 6'd42 || f == 6'd43 ||
                   f == 6'd0 || f == 6'd2 || f == 6'd3 || f == 6'd4 ||
                   f == 6'd6 || f == 6'd7) begin
        d.kind = K_ALU; d.regdst = 2'd1;
      end else begin
        d.legal = 1'b0;
      end
    end else if (o == 6'd1) begin
      d.kind = K_BR; d.ext = 1'b1;
      if (b == 5'd0)      d.branch = 3'd6;
      else if (b == 5'd1) d.branch = 3'd3;
      else                d.legal  = 1'b0;
    end else if (o == 6'd2) begin
      d.kind = K_JMP; d.jump = 2'd1;
    end else if (o == 6'd3) begin
      d.kind = K_LINK; d.jump = 2'd1; d.regdst = 2'd2; d.memtoreg = 2'd3;
    end else if (o == 6'd4) begin
      d.kind = K_BR; d.ext = 1'b1; d.branch = 3'd1;
    end else if (o == 6'd5) begin
      d.kind = K_BR; d.ext = 1'b1; d.branch = 3'd2;
    end else if (o == 6'd6) begin
      d.kind = K_BR; d.ext = 1'b1; d.branch = 3'd5;
    end else if (o == 6'd7) begin
      d.kind = K_BR; d.ext = 1'b1; d.branch = 3'd4;
    end else if (o >= 6'd8 && o <= 6'd11) begin
      d.ext = 1'b1; d.alusrc = 1'b1;
    end else if (o >= 6'd12 && o <= 6'd14) begin
      d.alusrc = 1'b1;
    end else if (o == 6'd15) begin
      d.alusrc = 1'b1; d.memtoreg = 2'd2;
    end else if (o == 6'd35 || o == 6'd32 || o == 6'd36) begin
      d.kind = K_LOAD; d.ext = 1'b1; d.alusrc = 1'b1; d.memtoreg = 2'd1;
      d.memwr = (o == 6'd32) ? 3'd2 : (o == 6'd36) ? 3'd3 : 3'd0;
    end else if (o == 6'd43 || o == 6'd40) begin
      d.kind = K_STORE; d.ext = 1'b1; d.alusrc = 1'b1;
      d.memwr = (o == 6'd40) ? 3'd5 : 3'd1;
    end else begin
      d.legal = 1'b0;
    end
    return d;
  endfunction

  task automatic chk_ctl(input ctl_t e, input string tag);
    ctl_t obs;
    obs = {imem_req, dmem_req, IRWr, PCWr, RegWr, ExtOp, ALUSrc,
           RegDst, Jump, MemtoReg, Branch, MemWr, illegal, bus_err};
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CNT_W-1:0] ec, ei;
`ifdef MC_CTRL_PERF_EN
    ec = cyc_m[CNT_W-1:0];
    ei = instr_m[CNT_W-1:0];
`else
    ec = '0;
    ei = '0;
`endif
    n_cmp++;
    assert ({cycle_cnt, instr_cnt} === {ec, ei}) else begin
      n_err++;
      $error("FAIL %s counters observed=%0d/%0d expected=%0d/%0d",
             tag, cycle_cnt, instr_cnt, ec, ei);
    end
  endtask

  // One clock: drive at negedge, check 1ns later, then let the edge happen.
  task automatic step(input ctl_t e, input logic ir, input logic dr,
                      input logic [5:0] o, input logic [5:0] f, input logic [4:0] b,
                      input string tag, input bit done);
    @(negedge Clk);
    imem_rdy = ir; dmem_rdy = dr; op = o; func = f; branop = b;
    #1;
    chk_ctl(e, tag);
    chk_cnt(tag);
    @(posedge Clk);
    cyc_m = cyc_m + 32'd1;
    if (done) instr_m = instr_m + 32'd1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  // Run one instruction: iw/mw are the ready delays for fetch and data access.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] b,
                           input int iw, input int mw);
    dec_t d;
    ctl_t e;
    d = ref_decode(o, f, b);
    for (int k = 0; k <= iw; k++) begin
      e = '0;
      if (k >= iw) begin
        e.imem_req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
        step(e, 1'b1, rbit(), r6(), r6(), 5'($urandom), "if_rdy", 1'b0);
      end else if (WAIT_MAX != 0 && k == WAIT_MAX) begin
        e.bus_err = 1'b1;
        step(e, 1'b0, rbit(), r6(), r6(), 5'($urandom), "if_timeout", 1'b0);
        return;
      end else begin
        e.imem_req = 1'b1;
        step(e, 1'b0, rbit(), r6(), r6(), 5'($urandom), "if_wait", 1'b0);
      end
    end
    e = '0;
    e.illegal = ~d.legal;
    step(e, rbit(), rbit(), o, f, b, "id", 1'b0);
    if (!d.legal) return;
    e = '0;
    e.extop = d.ext; e.alusrc = d.alusrc;
    if (d.kind == K_BR || d.kind == K_JMP || d.kind == K_LINK) begin
      e.branch = d.branch;
      e.jump   = d.jump;
      if (d.kind == K_LINK) begin
        e.regwr = 1'b1; e.regdst = 2'd2; e.memtoreg = 2'd3;
      end
      step(e, rbit(), rbit(), r6(), r6(), 5'($urandom), "ex_ctl", 1'b1);
      return;
    end
    step(e, rbit(), rbit(), r6(), r6(), 5'($urandom), "ex", 1'b0);
    if (d.kind == K_LOAD || d.kind == K_STORE) begin
      for (int k = 0; k <= mw; k++) begin
        e = '0;
        if (k >= mw) begin
          e.dmem_req = 1'b1; e.memwr = d.memwr;
          step(e, rbit(), 1'b1, r6(), r6(), 5'($urandom), "mem_rdy", d.kind == K_STORE);
          if (d.kind == K_STORE) return;
          break;
        end else if (WAIT_MAX != 0 && k == WAIT_MAX) begin
          e.bus_err = 1'b1;
          step(e, rbit(), 1'b0, r6(), r6(), 5'($urandom), "mem_timeout", 1'b0);
          return;
        end else begin
          e.dmem_req = 1'b1; e.memwr = d.memwr;
          step(e, rbit(), 1'b0, r6(), r6(), 5'($urandom), "mem_wait", 1'b0);
        end
      end
    end
    e = '0;
    e.regwr = 1'b1; e.regdst = d.regdst; e.memtoreg = d.memtoreg;
    step(e, rbit(), rbit(), r6(), r6(), 5'($urandom), "wb", 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    cyc_m   = 32'd0;
    instr_m = 32'd0;
    chk_ctl('0, tag);
    chk_cnt(tag);
  endtask

  logic [5:0] legal_ops [22] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
                                 6'd15, 6'd35, 6'd32, 6'd36, 6'd43, 6'd40, 6'd0};
  logic [5:0] r_funcs [8] = '{6'd32, 6'd34, 6'd36, 6'd42, 6'd8, 6'd9, 6'd2, 6'd7};

  initial begin
    ctl_t e;
    logic [5:0] ro, rf;
    Rst_n = 1'b0; op = 6'd0; func = 6'd0; branop = 5'd0;
    imem_rdy = 1'b1; dmem_rdy = 1'b1;
    repeat (2) @(posedge Clk);
    #2 chk_reset("reset_hold");
    @(posedge Clk);
    #2 Rst_n = 1'b1;

    run_instr(6'd0, 6'd32, 5'd0, 0, 0);    // add, zero wait
    run_instr(6'd35, 6'd0, 5'd0, 0, 3);    // lw, dmem_rdy after 3 cycles
    run_instr(6'd40, 6'd0, 5'd0, 1, 2);    // sb
    run_instr(6'd1, 6'd0, 5'd0, 0, 0);     // bltz
    run_instr(6'd1, 6'd0, 5'd1, 0, 0);     // bgez
    run_instr(6'd1, 6'd0, 5'd2, 0, 0);     // bad branop
    run_instr(6'd0, 6'd32, 5'd0, 9, 0);    // fetch timeout
    run_instr(6'd0, 6'd32, 5'd0, 0, 0);    // refetch
    run_instr(6'd63, 6'd0, 5'd0, 0, 0);    // illegal op
    run_instr(6'd0, 6'd63, 5'd0, 0, 0);    // illegal func
    run_instr(6'd43, 6'd0, 5'd0, 0, 7);    // sw data timeout
    run_instr(6'd36, 6'd0, 5'd0, 4, 4);    // ready on the limit cycle wins
    run_instr(6'd3, 6'd0, 5'd0, 0, 0);     // jal
    run_instr(6'd0, 6'd9, 5'd0, 0, 0);     // jalr
    run_instr(6'd0, 6'd8, 5'd0, 2, 0);     // jr
    run_instr(6'd2, 6'd0, 5'd0, 0, 0);     // j
    run_instr(6'd15, 6'd0, 5'd0, 0, 0);    // lui
    run_instr(6'd13, 6'd0, 5'd0, 0, 0);    // ori

    // reset while an add sits in S_WB: nothing may be written
    e = '0; e.imem_req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
    step(e, 1'b1, 1'b0, 6'd0, 6'd0, 5'd0, "mid_if", 1'b0);
    step('0, 1'b0, 1'b0, 6'd0, 6'd32, 5'd0, "mid_id", 1'b0);
    step('0, 1'b0, 1'b0, 6'd0, 6'd32, 5'd0, "mid_ex", 1'b0);
    #2 Rst_n = 1'b0;
    #1 chk_reset("reset_mid");
    @(posedge Clk);
    #2 chk_reset("reset_mid_hold");
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    e = '0; e.imem_req = 1'b1;
    step(e, 1'b0, 1'b1, 6'd0, 6'd0, 5'd0, "after_reset_if", 1'b0);
    e.irwr = 1'b1; e.pcwr = 1'b1;
    step(e, 1'b1, 1'b0, 6'd0, 6'd0, 5'd0, "after_reset_rdy", 1'b0);
    e = '0; e.illegal = 1'b1;
    step(e, 1'b0, 1'b0, 6'd63, 6'd0, 5'd0, "after_reset_ill", 1'b0);

    for (int n = 0; n < 300; n++) begin
      ro = ($urandom_range(0, 7) == 0) ? r6() : legal_ops[$urandom_range(0, 21)];
      rf = ($urandom_range(0, 5) == 0) ? r6() : r_funcs[$urandom_range(0, 7)];
      run_instr(ro, rf, 5'($urandom_range(0, 2)),
                $urandom_range(0, 6), $urandom_range(0, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
